collision_event_encoder: RTL

- Consumer end of the sprite-hit comparator interface.
- On a load strobe, captures the per-sprite hit vector (bit i = sprite i+1 overlaps the checked coordinate; top bit unused/zero).
- Serialises the set bits into a stream of sprite-index events over a valid/ready handshake, lowest index first.
- The game/collision logic downstream consumes these events.

---
 rtl/collision_event_encoder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/collision_event_encoder.sv
// Captures a sprite-hit vector and replays its set bits as index events over
// a valid/ready handshake, lowest sprite index first.
module collision_event_encoder #(
    parameter int NUM_SPR = 31,
    parameter int VEC_W   = 32,
    parameter int IDX_W   = 5,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [VEC_W-1:0] hit_vec,
    output logic             busy,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic [CNT_W-1:0] hit_count,
    output logic             scan_done,
    output logic             load_dropped
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t               state_reg;
    logic [NUM_SPR-1:0]   pending_reg;
    logic                 busy_reg;
    logic                 evt_valid_reg;
    logic [IDX_W-1:0]     evt_idx_reg;
    logic [CNT_W-1:0]     hit_count_reg;
    logic                 scan_done_reg;
    logic                 load_dropped_reg;

    logic [NUM_SPR-1:0]   masked_vec;
    logic [NUM_SPR-1:0]   clear_mask;
    logic [NUM_SPR-1:0]   remainder;
    logic [CNT_W-1:0]     masked_pop;
    logic [IDX_W-1:0]     masked_lsb;
    logic [IDX_W-1:0]     remainder_lsb;
    logic                 handshake;
    logic                 unused_hi_bits;

    // Bits above the sprite range carry no sprite and are never stored.
    assign masked_vec     = hit_vec[NUM_SPR-1:0];
    assign unused_hi_bits = ^hit_vec[VEC_W-1:NUM_SPR];

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_SPR-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPR; gi++) begin : g_clear
            assign clear_mask[gi] = (evt_idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign remainder     = pending_reg & ~clear_mask;
    assign masked_lsb    = lowest_set(masked_vec);
    assign remainder_lsb = lowest_set(remainder);
    assign handshake     = evt_valid_reg & evt_ready;

    always_comb begin
        masked_pop = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            masked_pop = masked_pop + CNT_W'(masked_vec[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            pending_reg      <= '0;
            busy_reg         <= 1'b0;
            evt_valid_reg    <= 1'b0;
            evt_idx_reg      <= '0;
            hit_count_reg    <= '0;
            scan_done_reg    <= 1'b0;
            load_dropped_reg <= 1'b0;
        end else begin
            scan_done_reg    <= 1'b0;
            load_dropped_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        hit_count_reg <= masked_pop;
                        if (masked_vec != '0) begin
                            pending_reg   <= masked_vec;
                            evt_idx_reg   <= masked_lsb;
                            evt_valid_reg <= 1'b1;
                            busy_reg      <= 1'b1;
                            state_reg     <= EMIT;
                        end else begin
                            scan_done_reg <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // A load during emission is dropped, even on the final accept.
                    if (load) load_dropped_reg <= 1'b1;
                    if (handshake) begin
                        pending_reg <= remainder;
                        if (remainder != '0) begin
                            evt_idx_reg <= remainder_lsb;
                        end else begin
                            evt_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            scan_done_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy         = busy_reg;
    assign evt_valid    = evt_valid_reg;
    assign evt_idx      = evt_idx_reg;
    assign hit_count    = hit_count_reg;
    assign scan_done    = scan_done_reg;
    assign load_dropped = load_dropped_reg;

endmodule
